multi_cycle_execute_stage3: RTL and testbench
=============================================

// Module: multi_cycle_execute_stage3
//
// PURPOSE
// Third stage of the multi-cycle (floating point) execute pipeline; consumes mx2 outputs, feeds mx4/writeback.
// Per lane, normalizes the raw FP add/sub significand produced upstream: carry-out right shift, or leading-zero
// count plus left shift, with matching exponent adjust. Flushes underflow to zero, saturates overflow to infinity.
// Single register stage. Instructions squashed on a memory-pipeline rollback of their thread.
//
// PARAMETERS
// LANES      16  vector lanes (matches `VECTOR_LANES)
// INSTR_W    -   width of decoded_instruction_t; passed through opaquely
//
// PORTS
// clk                      in   1          clock
// reset                    in   1          async, active-high
// mx2_instruction_valid    in   1          stage-2 slot holds an instruction
// mx2_instruction          in   INSTR_W    decoded instruction
// mx2_mask_value           in   LANES      lane enable mask
// mx2_thread_idx           in   thread_idx_t  issuing thread
// mx2_subcycle             in   subcycle_t    subcycle number
// mx2_significand          in   LANES*25   per lane: [24]=carry, [23]=hidden bit, [22:0] fraction; lane n at [25n+:25]
// mx2_exponent             in   LANES*8    per-lane biased exponent of larger operand
// mx2_sign                 in   LANES      per-lane result sign
// wb_rollback_en           in   1          rollback request
// wb_rollback_thread_idx   in   thread_idx_t  thread rolled back
// wb_rollback_pipeline     in   pipeline_sel_t  pipeline that raised rollback
// mx3_instruction_valid    out  1          registered valid
// mx3_instruction          out  INSTR_W    registered instruction
// mx3_mask_value           out  LANES      registered mask
// mx3_thread_idx           out  thread_idx_t  registered thread
// mx3_subcycle             out  subcycle_t    registered subcycle
// mx3_result               out  LANES*32   per-lane IEEE-754 single {sign, exp[7:0], frac[22:0]}
//
// BEHAVIOUR
// - Reset (async): every output 0. Reset mid-operation discards in-flight instruction.
// - Latency 1 cycle; no stall/backpressure, new input accepted every cycle.
// - mx3_instruction_valid <= mx2_instruction_valid && !(wb_rollback_en && wb_rollback_thread_idx == mx2_thread_idx
//   && wb_rollback_pipeline == PIPE_MEM). Other-thread or non-memory rollbacks do not squash (single-cycle
//   pipe rollbacks were resolved before mx2). Data registers load every cycle regardless of valid.
// - Per lane (computed for all lanes; mask is passed through, not applied), E = exponent widened to 10-bit signed:
//   1. E == 255 (Inf/NaN in): exp 255, frac = significand[22:0] unchanged.
//   2. significand[24] == 1: frac = significand[23:1] (truncate); E+1 >= 255 -> exp 255, frac 0; else exp E+1.
//   3. significand[24:0] == 0: exact zero, exp 0, frac 0, sign preserved.
//   4. else lz = leading zeros of significand[23:0] (0..23); shifted = significand[23:0] << lz;
//      E-lz >= 1 -> exp E-lz, frac shifted[22:0]; E-lz <= 0 -> flush to zero (exp 0, frac 0). No denormals.
// - Rounding: truncate (toward zero) only; exponent math never wraps (10-bit signed intermediate).
// - Sign output = mx2_sign for that lane in all cases.
//
// TESTING
// 1. Lane0 sig 25'h1000000, exp 127, sign 0 (1.0+1.0) -> next cycle mx3_result[31:0] = 32'h40000000, valid 1.
// 2. Lane3 sig 25'h0000800, exp 130 (cancellation, lz=12) -> exp 118, frac 0 -> lane3 result 32'h3B000000.
// 3. Carry with exp 254 -> 32'h7F800000 (+Inf); sig 25'h0000001, exp 10 -> 32'h00000000 (flush); exp 255,
//    sig 25'h0400001 -> 32'h7FC00001 (NaN passthrough).
// 4. Valid input thread 2 with wb_rollback_en=1, thread 2, PIPE_MEM -> mx3_instruction_valid 0;
//    same with PIPE_SCYCLE or thread 1 -> valid 1.
// 5. Back-to-back valid inputs every cycle for 16 cycles, random lanes/masks -> outputs match model 1 cycle later.
// 6. Assert reset while valid instruction registered -> all outputs 0 immediately; after release, next input
//    propagates normally.

Source files
------------

// File: rtl/multi_cycle_execute_stage3.sv
// Multi-cycle FP pipeline stage 3: per-lane normalization of the raw add/sub significand,
// with overflow saturation to infinity and underflow flush to zero. One register stage.
module multi_cycle_execute_stage3 #(
    parameter int unsigned LANES      = 16,
    parameter int unsigned INSTR_W    = 64,
    parameter int unsigned THREAD_W   = 2,
    parameter int unsigned SUBCYCLE_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mx2_instruction_valid,
    input  logic [INSTR_W-1:0]      mx2_instruction,
    input  logic [LANES-1:0]        mx2_mask_value,
    input  logic [THREAD_W-1:0]     mx2_thread_idx,
    input  logic [SUBCYCLE_W-1:0]   mx2_subcycle,
    input  logic [LANES*25-1:0]     mx2_significand,
    input  logic [LANES*8-1:0]      mx2_exponent,
    input  logic [LANES-1:0]        mx2_sign,
    input  logic                    wb_rollback_en,
    input  logic [THREAD_W-1:0]     wb_rollback_thread_idx,
    input  logic [1:0]              wb_rollback_pipeline,
    output logic                    mx3_instruction_valid,
    output logic [INSTR_W-1:0]      mx3_instruction,
    output logic [LANES-1:0]        mx3_mask_value,
    output logic [THREAD_W-1:0]     mx3_thread_idx,
    output logic [SUBCYCLE_W-1:0]   mx3_subcycle,
    output logic [LANES*32-1:0]     mx3_result
);

    localparam int unsigned SIG_W   = 25;
    localparam int unsigned EXP_W   = 8;
    localparam int unsigned FRAC_W  = 23;
    localparam int unsigned RES_W   = 32;
    localparam logic [1:0]  PIPE_MEM = 2'd0;

    // Leading zeros of a nonzero 24-bit value; the highest set bit is the last one written.
    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] lz;
        lz = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (v[i]) lz = 5'(23 - i);
        end
        return lz;
    endfunction

    // Returns {exp[7:0], frac[22:0]} for one lane; sign is handled by the caller.
    function automatic logic [30:0] normalize(input logic [SIG_W-1:0] sig,
                                              input logic [EXP_W-1:0] exp_in);
        logic signed [9:0] e;
        logic signed [9:0] res_e;
        logic [4:0]        lz;
        logic [FRAC_W-1:0] frac;
        logic [30:0]       res;
        res   = '0;
        e     = signed'(10'(exp_in));
        res_e = '0;
        lz    = '0;
        frac  = '0;
        if (exp_in == 8'hFF) begin
            res = {8'hFF, sig[22:0]};
        end else if (sig[24]) begin
            res_e = e + 10'sd1;
            if (res_e >= 10'sd255) res = {8'hFF, 23'd0};
            else                   res = {8'(res_e), sig[23:1]};
        end else if (sig == '0) begin
            res = '0;
        end else begin
            lz    = lzc24(sig[23:0]);
            res_e = e - signed'(10'(lz));
            frac  = 23'(sig[23:0] << lz);
            if (res_e >= 10'sd1) res = {8'(res_e), frac};
            else                 res = '0;
        end
        return res;
    endfunction

    logic                    valid_d, valid_q;
    logic [INSTR_W-1:0]      instruction_d, instruction_q;
    logic [LANES-1:0]        mask_d, mask_q;
    logic [THREAD_W-1:0]     thread_d, thread_q;
    logic [SUBCYCLE_W-1:0]   subcycle_d, subcycle_q;
    logic [LANES*RES_W-1:0]  result_d, result_q;

    // Squash only on a memory-pipe rollback of the same thread.
    always_comb begin
        valid_d       = mx2_instruction_valid
                        && !(wb_rollback_en
                             && (wb_rollback_thread_idx == mx2_thread_idx)
                             && (wb_rollback_pipeline == PIPE_MEM));
        instruction_d = mx2_instruction;
        mask_d        = mx2_mask_value;
        thread_d      = mx2_thread_idx;
        subcycle_d    = mx2_subcycle;
    end

    // All lanes are normalized; the mask is only passed through.
    always_comb begin
        result_d = '0;
        for (int n = 0; n < int'(LANES); n++) begin
            result_d[RES_W*n +: RES_W] = {mx2_sign[n],
                normalize(mx2_significand[SIG_W*n +: SIG_W], mx2_exponent[EXP_W*n +: EXP_W])};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q       <= 1'b0;
            instruction_q <= '0;
            mask_q        <= '0;
            thread_q      <= '0;
            subcycle_q    <= '0;
            result_q      <= '0;
        end else begin
            valid_q       <= valid_d;
            instruction_q <= instruction_d;
            mask_q        <= mask_d;
            thread_q      <= thread_d;
            subcycle_q    <= subcycle_d;
            result_q      <= result_d;
        end
    end

    assign mx3_instruction_valid = valid_q;
    assign mx3_instruction       = instruction_q;
    assign mx3_mask_value        = mask_q;
    assign mx3_thread_idx        = thread_q;
    assign mx3_subcycle          = subcycle_q;
    assign mx3_result            = result_q;

endmodule

// File: tb/tb_multi_cycle_execute_stage3.sv
// Self-checking bench for multi_cycle_execute_stage3: directed corner cases plus
// randomized back-to-back traffic checked against an arithmetic reference model.
module tb_multi_cycle_execute_stage3;

    localparam int LANES      = 16;
    localparam int INSTR_W    = 64;
    localparam int THREAD_W   = 2;
    localparam int SUBCYCLE_W = 4;
    localparam logic [1:0] PIPE_MEM    = 2'd0;
    localparam logic [1:0] PIPE_SCYCLE = 2'd1;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    mx2_instruction_valid;
    logic [INSTR_W-1:0]      mx2_instruction;
    logic [LANES-1:0]        mx2_mask_value;
    logic [THREAD_W-1:0]     mx2_thread_idx;
    logic [SUBCYCLE_W-1:0]   mx2_subcycle;
    logic [LANES*25-1:0]     mx2_significand;
    logic [LANES*8-1:0]      mx2_exponent;
    logic [LANES-1:0]        mx2_sign;
    logic                    wb_rollback_en;
    logic [THREAD_W-1:0]     wb_rollback_thread_idx;
    logic [1:0]              wb_rollback_pipeline;
    logic                    mx3_instruction_valid;
    logic [INSTR_W-1:0]      mx3_instruction;
    logic [LANES-1:0]        mx3_mask_value;
    logic [THREAD_W-1:0]     mx3_thread_idx;
    logic [SUBCYCLE_W-1:0]   mx3_subcycle;
    logic [LANES*32-1:0]     mx3_result;

    int checks = 0;
    int failures = 0;

    logic                  exp_valid;
    logic [INSTR_W-1:0]    exp_instr;
    logic [LANES-1:0]      exp_mask;
    logic [THREAD_W-1:0]   exp_thread;
    logic [SUBCYCLE_W-1:0] exp_sub;
    logic [31:0]           exp_res [LANES];

    multi_cycle_execute_stage3 #(
        .LANES(LANES), .INSTR_W(INSTR_W), .THREAD_W(THREAD_W), .SUBCYCLE_W(SUBCYCLE_W)
    ) dut (
        .clk(clk), .reset(reset),
        .mx2_instruction_valid(mx2_instruction_valid),
        .mx2_instruction(mx2_instruction),
        .mx2_mask_value(mx2_mask_value),
        .mx2_thread_idx(mx2_thread_idx),
        .mx2_subcycle(mx2_subcycle),
        .mx2_significand(mx2_significand),
        .mx2_exponent(mx2_exponent),
        .mx2_sign(mx2_sign),
        .wb_rollback_en(wb_rollback_en),
        .wb_rollback_thread_idx(wb_rollback_thread_idx),
        .wb_rollback_pipeline(wb_rollback_pipeline),
        .mx3_instruction_valid(mx3_instruction_valid),
        .mx3_instruction(mx3_instruction),
        .mx3_mask_value(mx3_mask_value),
        .mx3_thread_idx(mx3_thread_idx),
        .mx3_subcycle(mx3_subcycle),
        .mx3_result(mx3_result)
    );

    always #5 clk = ~clk;

    // Reference: treat the significand as an integer and renormalize by doubling.
    function automatic logic [31:0] model_lane(input logic [24:0] sig, input logic [7:0] ex,
                                               input logic sg);
        int m;
        int e;
        if (ex == 8'd255) return {sg, 8'hFF, sig[22:0]};
        if (sig >= 25'h1000000) begin
            e = int'(ex) + 1;
            if (e >= 255) return {sg, 8'hFF, 23'd0};
            return {sg, 8'(e), sig[23:1]};
        end
        if (sig == 25'd0) return {sg, 31'd0};
        m = int'(sig);
        e = int'(ex);
        while (m < 32'h800000) begin
            m = m * 2;
            e = e - 1;
        end
        if (e < 1) return {sg, 31'd0};
        return {sg, 8'(e), 23'(m - 32'h800000)};
    endfunction

    task automatic set_lane(input int n, input logic [24:0] s, input logic [7:0] e, input logic sg);
        mx2_significand[25*n +: 25] = s;
        mx2_exponent[8*n +: 8]      = e;
        mx2_sign[n]                 = sg;
    endtask

    // Random lane mix covering carry, normalized, cancellation, zero and exponent corners.
    task automatic randomize_lanes();
        logic [24:0] s;
        logic [7:0]  e;
        for (int n = 0; n < LANES; n++) begin
            case ($urandom_range(0, 4))
                0: s = 25'h1000000 | 25'($urandom_range(0, 32'hFFFFFF));
                1: s = 25'h0800000 | 25'($urandom_range(0, 32'h7FFFFF));
                2: s = 25'($urandom_range(1, 32'hFFFF));
                3: s = 25'd0;
                default: s = 25'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: e = 8'd0;
                1: e = 8'd1;
                2: e = 8'd254;
                3: e = 8'd255;
                default: e = 8'($urandom);
            endcase
            set_lane(n, s, e, 1'($urandom));
        end
        mx2_instruction = {32'($urandom), 32'($urandom)};
        mx2_mask_value  = 16'($urandom);
        mx2_thread_idx  = 2'($urandom);
        mx2_subcycle    = 4'($urandom);
    endtask

    task automatic capture_expected(input logic v);
        exp_valid  = v;
        exp_instr  = mx2_instruction;
        exp_mask   = mx2_mask_value;
        exp_thread = mx2_thread_idx;
        exp_sub    = mx2_subcycle;
        for (int n = 0; n < LANES; n++)
            exp_res[n] = model_lane(mx2_significand[25*n +: 25], mx2_exponent[8*n +: 8], mx2_sign[n]);
    endtask

    task automatic check_outputs(input string tag);
        checks++;
        assert (mx3_instruction_valid === exp_valid) else begin
            failures++;
            $error("FAIL %s valid got=%b exp=%b", tag, mx3_instruction_valid, exp_valid);
        end
        checks++;
        assert (mx3_instruction === exp_instr) else begin
            failures++;
            $error("FAIL %s instr got=%h exp=%h", tag, mx3_instruction, exp_instr);
        end
        checks++;
        assert (mx3_mask_value === exp_mask && mx3_thread_idx === exp_thread
                && mx3_subcycle === exp_sub) else begin
            failures++;
            $error("FAIL %s side got=%h/%h/%h exp=%h/%h/%h", tag, mx3_mask_value, mx3_thread_idx,
                   mx3_subcycle, exp_mask, exp_thread, exp_sub);
        end
        for (int n = 0; n < LANES; n++) begin
            checks++;
            assert (mx3_result[32*n +: 32] === exp_res[n]) else begin
                failures++;
                $error("FAIL %s lane%0d got=%h exp=%h", tag, n, mx3_result[32*n +: 32], exp_res[n]);
            end
        end
    endtask

    task automatic check_const(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, want);
        end
    endtask

    // Drive rollback/valid, predict, clock, and compare 1ns after the edge.
    task automatic step(input string tag, input logic v, input logic rb_en,
                        input logic [1:0] rb_thr, input logic [1:0] rb_pipe, input logic want_v);
        mx2_instruction_valid  = v;
        wb_rollback_en         = rb_en;
        wb_rollback_thread_idx = rb_thr;
        wb_rollback_pipeline   = rb_pipe;
        capture_expected(want_v);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        reset = 1'b1;
        mx2_instruction_valid = 1'b0;
        wb_rollback_en = 1'b0;
        wb_rollback_thread_idx = '0;
        wb_rollback_pipeline = PIPE_SCYCLE;
        randomize_lanes();
        @(posedge clk);
        #1;
        exp_valid = 1'b0; exp_instr = '0; exp_mask = '0; exp_thread = '0; exp_sub = '0;
        for (int n = 0; n < LANES; n++) exp_res[n] = '0;
        check_outputs("reset");
        reset = 1'b0;

        // 1.0 + 1.0 carry case on lane 0
        randomize_lanes();
        set_lane(0, 25'h1000000, 8'd127, 1'b0);
        step("t1", 1'b1, 1'b0, 2'd0, PIPE_MEM, 1'b1);
        check_const("t1_lane0", mx3_result[31:0], 32'h40000000);

        // cancellation with 12 leading zeros on lane 3
        randomize_lanes();
        set_lane(3, 25'h0000800, 8'd130, 1'b0);
        step("t2", 1'b1, 1'b0, 2'd0, PIPE_MEM, 1'b1);
        check_const("t2_lane3", mx3_result[3*32 +: 32], 32'h3B000000);

        // overflow to Inf, underflow flush, NaN passthrough
        randomize_lanes();
        set_lane(0, 25'h1000000, 8'd254, 1'b0);
        set_lane(1, 25'h0000001, 8'd10, 1'b0);
        set_lane(2, 25'h0400001, 8'd255, 1'b0);
        set_lane(4, 25'h0000000, 8'd77, 1'b1);
        step("t3", 1'b1, 1'b0, 2'd0, PIPE_MEM, 1'b1);
        check_const("t3_inf", mx3_result[31:0], 32'h7F800000);
        check_const("t3_flush", mx3_result[63:32], 32'h00000000);
        check_const("t3_nan", mx3_result[95:64], 32'h7FC00001);
        check_const("t3_negzero", mx3_result[159:128], 32'h80000000);

        // rollback squash rules
        randomize_lanes();
        mx2_thread_idx = 2'd2;
        step("rb_mem_same", 1'b1, 1'b1, 2'd2, PIPE_MEM, 1'b0);
        step("rb_scycle", 1'b1, 1'b1, 2'd2, PIPE_SCYCLE, 1'b1);
        step("rb_other_thr", 1'b1, 1'b1, 2'd1, PIPE_MEM, 1'b1);
        step("rb_none", 1'b1, 1'b0, 2'd2, PIPE_MEM, 1'b1);
        step("invalid_in", 1'b0, 1'b0, 2'd0, PIPE_MEM, 1'b0);

        // back-to-back random traffic
        for (int c = 0; c < 24; c++) begin
            logic       en;
            logic [1:0] thr;
            logic [1:0] pipe;
            logic       v;
            randomize_lanes();
            en   = 1'($urandom);
            thr  = 2'($urandom);
            pipe = 2'($urandom_range(0, 2));
            v    = ($urandom_range(0, 7) != 0);
            step("rand", v, en, thr, pipe,
                 v && !(en && thr == mx2_thread_idx && pipe == PIPE_MEM));
        end

        // async reset with a valid instruction held in the register
        randomize_lanes();
        step("pre_reset", 1'b1, 1'b0, 2'd0, PIPE_MEM, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        exp_valid = 1'b0; exp_instr = '0; exp_mask = '0; exp_thread = '0; exp_sub = '0;
        for (int n = 0; n < LANES; n++) exp_res[n] = '0;
        check_outputs("async_reset");
        @(negedge clk);
        reset = 1'b0;
        randomize_lanes();
        step("post_reset", 1'b1, 1'b0, 2'd0, PIPE_MEM, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
